// File: rtl/sr_ff_pkg.sv
// rtl/sr_ff_pkg.sv - S=R=1 resolution modes and the per-bit next-state function
package sr_ff_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SET   = 2'b01,
    MODE_RESET = 2'b10,
    MODE_JK    = 2'b11
  } mode_e;

  function automatic logic sr_next(input logic q, input logic s, input logic r, input mode_e mode);
    logic nq;
    nq = q;
    case ({s, r})
      2'b00:   nq = q;
      2'b10:   nq = 1'b1;
      2'b01:   nq = 1'b0;
      default: begin
        case (mode)
          MODE_HOLD:  nq = q;
          MODE_SET:   nq = 1'b1;
          MODE_RESET: nq = 1'b0;
          default:    nq = ~q;
        endcase
      end
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/param_sr_ff_bank_if.sv
// rtl/param_sr_ff_bank_if.sv - control inputs and state/flag outputs of the SR flip-flop bank
interface param_sr_ff_bank_if
  import sr_ff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  mode_e            mode;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             clr_sticky;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] illegal;
  logic             illegal_any;
  logic [WIDTH-1:0] illegal_sticky;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output en, mode, s, r, clr_sticky,
    input  q, qn, illegal, illegal_any, illegal_sticky, illegal_cnt
  );

  modport slave (
    input  en, mode, s, r, clr_sticky,
    output q, qn, illegal, illegal_any, illegal_sticky, illegal_cnt
  );
endinterface

// File: rtl/sr_ff_cell.sv
// rtl/sr_ff_cell.sv - one gated SR flip-flop bit with registered S=R=1 detection
module sr_ff_cell
  import sr_ff_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  en_i,
  input  mode_e mode_i,
  input  logic  s_i,
  input  logic  r_i,
  output logic  q_o,
  output logic  illegal_o,
  output logic  illegal_next_o
);

  logic q_q, q_d;
  logic ill_q, ill_d;

  always_comb begin
    q_d   = q_q;
    ill_d = 1'b0;
    if (en_i) begin
      q_d   = sr_next(q_q, s_i, r_i, mode_i);
      ill_d = s_i & r_i & (mode_i != MODE_JK);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q   <= RST_BIT;
      ill_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ill_q <= ill_d;
    end
  end

  assign q_o            = q_q;
  assign illegal_o      = ill_q;
  assign illegal_next_o = ill_d;

endmodule

// File: rtl/param_sr_ff_bank.sv
// rtl/param_sr_ff_bank.sv - WIDTH-bit gated SR flip-flop bank with sticky illegal flags
// Optional saturating illegal-cycle counter enabled by macro SR_FF_BANK_ILLEGAL_CNT_EN.
module param_sr_ff_bank
  import sr_ff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic               clk,
  input logic               rst,
  param_sr_ff_bank_if.slave bus
);

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] ill_w;
  logic [WIDTH-1:0] ill_next_w;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic             any_q, any_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell #(.RST_BIT(RST_VAL[i])) u_cell (
      .clk_i          (clk),
      .rst_i          (rst),
      .en_i           (bus.en),
      .mode_i         (bus.mode),
      .s_i            (bus.s[i]),
      .r_i            (bus.r[i]),
      .q_o            (q_w[i]),
      .illegal_o      (ill_w[i]),
      .illegal_next_o (ill_next_w[i])
    );
  end

  // A fresh illegal bit in the clear cycle survives the clear.
  always_comb begin
    sticky_d = (bus.clr_sticky ? '0 : sticky_q) | ill_next_w;
    any_d    = |ill_next_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
      any_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      any_q    <= any_d;
    end
  end

`ifdef SR_FF_BANK_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = bus.clr_sticky ? '0 : cnt_q;
    if (any_d && (cnt_d != {CNT_W{1'b1}})) begin
      cnt_d = cnt_d + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.illegal_cnt = cnt_q;
`else
  assign bus.illegal_cnt = {CNT_W{1'b0}};
`endif

  assign bus.q              = q_w;
  assign bus.qn             = ~q_w;
  assign bus.illegal        = ill_w;
  assign bus.illegal_any    = any_q;
  assign bus.illegal_sticky = sticky_q;

endmodule

// File: tb/tb_param_sr_ff_bank.sv
// tb/tb_param_sr_ff_bank.sv - scoreboard bench for param_sr_ff_bank against a vector-level model
module tb_param_sr_ff_bank;
  import sr_ff_pkg::*;

  localparam int         W   = 8;
  localparam int         CW  = 8;
  localparam logic [7:0] RST = 8'h00;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] qn;
    logic [7:0] ill;
    logic       any;
    logic [7:0] sticky;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  param_sr_ff_bank_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  param_sr_ff_bank #(.WIDTH(W), .CNT_W(CW), .RST_VAL(RST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] m_q;
  logic [7:0] m_sticky;
  int         m_cnt;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model works on whole vectors: S&R bits take the mode-wide resolution value.
  task automatic step(input logic rst_v, input logic en_v, input logic [1:0] mode_v,
                      input logic [7:0] s_v, input logic [7:0] r_v, input logic clr_v);
    logic [7:0] both, res, ill;
    exp_t e;
    @(negedge clk);
    rst = rst_v; bus.en = en_v; bus.mode = mode_e'(mode_v);
    bus.s = s_v; bus.r = r_v; bus.clr_sticky = clr_v;
    if (rst_v) begin
      m_q = RST; ill = 8'h00; m_sticky = 8'h00; m_cnt = 0;
    end else begin
      both = s_v & r_v;
      ill  = (en_v && mode_v != 2'b11) ? both : 8'h00;
      if (en_v) begin
        case (mode_v)
          2'b00:   res = m_q;
          2'b01:   res = 8'hFF;
          2'b10:   res = 8'h00;
          default: res = ~m_q;
        endcase
        m_q = (m_q & ~(s_v | r_v)) | (s_v & ~r_v) | (both & res);
      end
      m_sticky = (clr_v ? 8'h00 : m_sticky) | ill;
      if (clr_v) m_cnt = 0;
      if (ill != 8'h00 && m_cnt < 255) m_cnt = m_cnt + 1;
    end
    e.q = m_q; e.qn = ~m_q; e.ill = ill; e.any = |ill; e.sticky = m_sticky;
`ifdef SR_FF_BANK_ILLEGAL_CNT_EN
    e.cnt = m_cnt[7:0];
`else
    e.cnt = 8'h00;
`endif
    sb.push_back(e);
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q", bus.q, e.q);
        chk("qn", bus.qn, e.qn);
        chk("illegal", bus.illegal, e.ill);
        chk("illegal_any", {7'b0, bus.illegal_any}, {7'b0, e.any});
        chk("illegal_sticky", bus.illegal_sticky, e.sticky);
        chk("illegal_cnt", bus.illegal_cnt, e.cnt);
      end
    end
  end

  initial begin : stim
    rst = 1'b1; bus.en = 1'b0; bus.mode = MODE_HOLD;
    bus.s = 8'h00; bus.r = 8'h00; bus.clr_sticky = 1'b0;
    m_q = RST; m_sticky = 8'h00; m_cnt = 0;

    step(1, 0, 2'b00, 8'hFF, 8'h00, 0);
    step(1, 0, 2'b00, 8'hFF, 8'h00, 0);

    step(0, 1, 2'b00, 8'h0F, 8'h00, 0);
    step(0, 1, 2'b00, 8'h03, 8'h03, 0);

    step(0, 1, 2'b01, 8'hFF, 8'hFF, 0);
    step(0, 1, 2'b00, 8'h0F, 8'hF0, 0);
    step(0, 1, 2'b10, 8'hFF, 8'hFF, 0);
    step(0, 1, 2'b00, 8'h0F, 8'hF0, 0);
    step(0, 1, 2'b11, 8'hFF, 8'hFF, 0);

    step(0, 0, 2'b00, 8'hFF, 8'h00, 0);
    step(0, 0, 2'b00, 8'hFF, 8'hFF, 0);
    step(0, 1, 2'b00, 8'h80, 8'h80, 1);
    step(0, 0, 2'b00, 8'h00, 8'h00, 1);

    for (int i = 0; i < 300; i++) begin
      step(0, 1, 2'b00, 8'h01 | 8'($urandom), 8'hFF, 0);
    end
    step(0, 1, 2'b11, 8'hFF, 8'hFF, 0);

    step(1, 1, 2'b00, 8'hFF, 8'hFF, 0);
    step(0, 0, 2'b00, 8'h00, 8'h00, 0);

    for (int i = 0; i < 250; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
